// File: rtl/lsu_ctrl_pkg.sv
// Shared constants, FSM state encoding and request-decode helpers for the load/store sequencer.
package lsu_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 8;
    localparam int WORD_WIDTH     = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [2:0] {
        LSU_ST_IDLE   = 3'd0,
        LSU_ST_LOAD   = 3'd1,
        LSU_ST_RMW_RD = 3'd2,
        LSU_ST_WRITE  = 3'd3,
        LSU_ST_ERR    = 3'd4,
        LSU_ST_RESP   = 3'd5
    } lsu_state_e;

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic legal;
        if (we) begin
            legal = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
        end else begin
            legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        end
        return legal;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Halfword and word accesses ignore the low address bits they cannot use.
    function automatic logic [1:0] align_lane(input logic [2:0] funct3, input logic [1:0] lane);
        logic [1:0] aligned;
        case (funct3[1:0])
            2'b00:   aligned = lane;
            2'b01:   aligned = {lane[1], 1'b0};
            default: aligned = 2'b00;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request, response and data-memory bus of the load/store sequencer.
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = lsu_ctrl_pkg::MEM_ADDR_WIDTH
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [2:0]              req_funct3;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic [31:0]             req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;
    logic                    mem_wen;
    logic [2:0]              mem_type;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [31:0]             mem_wd;
    logic [31:0]             mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wen, mem_type, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wen, mem_type, mem_addr, mem_wd
    );
endinterface

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: load extract/extend and SB/SH merge into a captured word.
module lsu_lane_unit
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    // Extend the selected lane according to the load type.
    always_comb begin
        case (i_funct3)
            FUNCT3_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            FUNCT3_LBU: o_load_data = {24'd0, w_byte};
            FUNCT3_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            FUNCT3_LHU: o_load_data = {16'd0, w_half};
            FUNCT3_LW:  o_load_data = i_word;
            default:    o_load_data = 32'd0;
        endcase
    end

    // Overwrite only the addressed lane; a full-word store replaces everything.
    always_comb begin
        o_merge_data = i_word;
        case (i_funct3[1:0])
            2'b00:   o_merge_data[{i_lane, 3'b000} +: 8]   = i_wdata[7:0];
            2'b01:   o_merge_data[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merge_data = i_wdata;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: byte-addressed requests become full-word reads, writes or read-modify-writes.
// Macro LSU_ALIGN_CHECK_EN: misaligned H/W accesses return an error instead of being aligned down.
module lsu_ctrl #(
    parameter int ADDR_WIDTH = lsu_ctrl_pkg::MEM_ADDR_WIDTH,
    parameter int WORD_WIDTH = lsu_ctrl_pkg::WORD_WIDTH
)(
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);
    import lsu_ctrl_pkg::*;

    lsu_state_e              r_state;
    lsu_state_e              w_next;
    logic [2:0]              r_funct3;
    logic [1:0]              r_lane;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WORD_WIDTH-1:0]   r_wdata;
    logic [WORD_WIDTH-1:0]   r_wd;
    logic [WORD_WIDTH-1:0]   r_rdata;
    logic                    r_valid;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_bad;
    logic [WORD_WIDTH-1:0]   w_load_data;
    logic [WORD_WIDTH-1:0]   w_merge_data;

    assign bus.req_ready = (r_state == LSU_ST_IDLE) & ~rst;
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign bus.mem_wen   = (r_state == LSU_ST_WRITE);
    assign bus.mem_type  = bus.mem_wen ? FUNCT3_SW : FUNCT3_LW;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wd    = r_wd;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_err   = r_err;
    assign bus.rsp_rdata = r_rdata;

    // Decide whether an incoming request must be answered with an error.
    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        w_bad = ~funct3_legal(bus.req_we, bus.req_funct3)
              | is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
        w_bad = ~funct3_legal(bus.req_we, bus.req_funct3);
`endif
    end

    lsu_lane_unit u_lane (
        .i_funct3     (r_funct3),
        .i_lane       (r_lane),
        .i_word       (bus.mem_rd),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LSU_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_ST_IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_next = LSU_ST_ERR;
                    end else if (!bus.req_we) begin
                        w_next = LSU_ST_LOAD;
                    end else if (bus.req_funct3[1:0] == 2'b10) begin
                        w_next = LSU_ST_WRITE;
                    end else begin
                        w_next = LSU_ST_RMW_RD;
                    end
                end else begin
                    w_next = LSU_ST_IDLE;
                end
            end
            LSU_ST_LOAD:   w_next = LSU_ST_RESP;
            LSU_ST_RMW_RD: w_next = LSU_ST_WRITE;
            LSU_ST_WRITE:  w_next = LSU_ST_RESP;
            LSU_ST_ERR:    w_next = LSU_ST_RESP;
            LSU_ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = LSU_ST_IDLE;
                end else begin
                    w_next = LSU_ST_RESP;
                end
            end
            default:       w_next = LSU_ST_IDLE;
        endcase
    end

    // Request capture, merge register and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3 <= 3'd0;
            r_lane   <= 2'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wd     <= '0;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3 <= bus.req_funct3;
                r_lane   <= align_lane(bus.req_funct3, bus.req_addr[1:0]);
                r_addr   <= bus.req_addr[ADDR_WIDTH+1:2];
                r_wdata  <= bus.req_wdata;
                r_wd     <= bus.req_wdata;
            end
            case (r_state)
                LSU_ST_LOAD: begin
                    r_rdata <= w_load_data;
                    r_err   <= 1'b0;
                    r_valid <= 1'b1;
                end
                LSU_ST_RMW_RD: begin
                    r_wd <= w_merge_data;
                end
                LSU_ST_WRITE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_valid <= 1'b1;
                end
                LSU_ST_ERR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                    r_valid <= 1'b1;
                end
                LSU_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= r_valid;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a byte-lane reference model of the memory.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int AW = MEM_ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;

    lsu_ctrl_if #(.ADDR_WIDTH(AW)) bus();

    lsu_ctrl #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int          wen_total = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 4) return 32'h8899AABB;
        return {b ^ 8'hA5, b + 8'h3C, ~b, b ^ 8'h96};
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr] <= bus.mem_wd;
        end
    end

    assign bus.mem_rd = mem[bus.mem_addr];

    always @(negedge clk) begin
        if (bus.mem_wen) wen_total <= wen_total + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: the memory as an array of words, each access a byte/half/word lane.
    function automatic void ref_txn(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                                    input logic [31:0] wd, output logic [31:0] rd, output logic er,
                                    output int lat, output int wen);
        int          widx;
        int          b;
        int          sz;
        int          off;
        int          nbits;
        logic        legal;
        logic [63:0] word;
        logic [63:0] mask;
        logic [63:0] val;
        logic [63:0] m;
        widx  = int'(addr) / 4;
        b     = int'(addr) % 4;
        sz    = int'(f3) % 4;
        word  = {32'd0, ref_mem[widx]};
        legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        er    = !legal;
`ifdef LSU_ALIGN_CHECK_EN
        if (legal && ((sz == 1 && (b % 2) != 0) || (sz == 2 && b != 0))) er = 1'b1;
`endif
        rd  = 32'd0;
        lat = 1;
        wen = 0;
        if (er) return;
        off   = (sz == 0) ? b : (sz == 1) ? (b / 2) * 2 : 0;
        nbits = 8 << sz;
        mask  = (64'd1 << nbits) - 64'd1;
        if (!we) begin
            val = (word >> (8 * off)) & mask;
            if (f3 < 3'd4 && sz < 2 && val[nbits-1]) val = val | ~mask;
            rd = val[31:0];
        end else begin
            m = mask << (8 * off);
            val = (word & ~m) | (({32'd0, wd}) << (8 * off) & m);
            ref_mem[widx] = val[31:0];
            wen = 1;
            lat = (sz == 2) ? 1 : 2;
        end
    endfunction

    // Issue one request, wait for its response; returns at the negedge where rsp_valid is seen.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                           input logic [31:0] wd, input logic hold,
                           output logic [31:0] rd, output logic er, output int lat, output int wens);
        int k;
        int start;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.rsp_ready  = ~hold;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready 0, expected 1 within 20 cycles");
        end
        start = wen_total;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd   = bus.rsp_rdata;
        er   = bus.rsp_err;
        wens = wen_total - start;
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.exp_rd = exp_rd; v.exp_err = exp_err;
        vt.push_back(v);
    endtask

    logic [31:0] rd;
    logic [31:0] erd;
    logic        er;
    logic        eer;
    int          lat;
    int          elat;
    int          wens;
    int          ewen;
    int          start;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 10'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset values while rst is held high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata,           32'd0);
        check("reset_mem_wen",   {31'd0, bus.mem_wen},   32'd0);
        check("reset_mem_addr",  {24'd0, bus.mem_addr},  32'd0);
        check("reset_mem_wd",    bus.mem_wd,              32'd0);
        check("reset_mem_type",  {29'd0, bus.mem_type},  32'd2);
        mem_init = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Directed vectors around word 4 = 0x8899AABB.
        add_vec(1'b0, FUNCT3_LB,  10'h013, 32'h0, 32'hFFFFFF88, 1'b0);
        add_vec(1'b0, FUNCT3_LBU, 10'h013, 32'h0, 32'h00000088, 1'b0);
        add_vec(1'b0, FUNCT3_LH,  10'h012, 32'h0, 32'hFFFF8899, 1'b0);
        add_vec(1'b0, FUNCT3_LHU, 10'h012, 32'h0, 32'h00008899, 1'b0);
        add_vec(1'b0, FUNCT3_LW,  10'h010, 32'h0, 32'h8899AABB, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        add_vec(1'b0, FUNCT3_LH,  10'h011, 32'h0, 32'h00000000, 1'b1);
`else
        add_vec(1'b0, FUNCT3_LH,  10'h011, 32'h0, 32'hFFFFAABB, 1'b0);
`endif
        add_vec(1'b0, 3'd3,       10'h010, 32'h0, 32'h00000000, 1'b1);
        add_vec(1'b1, FUNCT3_SB,  10'h011, 32'h55, 32'h0, 1'b0);
        add_vec(1'b0, FUNCT3_LW,  10'h010, 32'h0, 32'h889955BB, 1'b0);
        add_vec(1'b1, FUNCT3_SH,  10'h012, 32'hFFFF1234, 32'h0, 1'b0);
        add_vec(1'b0, FUNCT3_LW,  10'h010, 32'h0, 32'h123455BB, 1'b0);
        add_vec(1'b1, 3'd4,       10'h010, 32'hDEADBEEF, 32'h0, 1'b1);
        add_vec(1'b0, FUNCT3_LW,  10'h010, 32'h0, 32'h123455BB, 1'b0);
        add_vec(1'b0, FUNCT3_LB,  10'h010, 32'h0, 32'hFFFFFFBB, 1'b0);

        foreach (vt[i]) begin
            ref_txn(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, erd, eer, elat, ewen);
            run_txn(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, 1'b0, rd, er, lat, wens);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
            check($sformatf("vec%0d_latency", i), lat, elat);
            check($sformatf("vec%0d_wen_pulses", i), wens, ewen);
        end

        // Response stalled by rsp_ready low; a second request must wait.
        ref_txn(1'b0, FUNCT3_LW, 10'h010, 32'h0, erd, eer, elat, ewen);
        run_txn(1'b0, FUNCT3_LW, 10'h010, 32'h0, 1'b1, rd, er, lat, wens);
        check("stall_first_rdata", rd, erd);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = FUNCT3_LB;
        bus.req_addr   = 10'h013;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_rsp_valid", c), {31'd0, bus.rsp_valid}, 32'd1);
            check($sformatf("stall%0d_rsp_rdata", c), bus.rsp_rdata, erd);
            check($sformatf("stall%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("stall_release_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Reset asserted while an SH sits in its read phase.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = FUNCT3_SH;
        bus.req_addr   = 10'h018;
        bus.req_wdata  = 32'h0000BEEF;
        start = wen_total;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rmw_rd_busy", {31'd0, bus.req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("abort_mem_wen",   {31'd0, bus.mem_wen},   32'd0);
        check("abort_mem_addr",  {24'd0, bus.mem_addr},  32'd0);
        check("abort_mem_wd",    bus.mem_wd,              32'd0);
        check("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_wen_pulses", wen_total - start, 32'd0);
        check("abort_mem_word6",  mem[6], ref_mem[6]);
        check("abort_req_ready_after", {31'd0, bus.req_ready}, 32'd1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [9:0]  r_addr;
            logic [31:0] r_wd;
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = 10'($urandom_range(0, 63));
            r_wd   = $urandom;
            ref_txn(r_we, r_f3, r_addr, r_wd, erd, eer, elat, ewen);
            run_txn(r_we, r_f3, r_addr, r_wd, 1'b0, rd, er, lat, wens);
            check($sformatf("rand%0d_rdata", n), rd, erd);
            check($sformatf("rand%0d_err", n), {31'd0, er}, {31'd0, eer});
            check($sformatf("rand%0d_latency", n), lat, elat);
            check($sformatf("rand%0d_wen", n), wens, ewen);
        end

        @(negedge clk);
        @(negedge clk);
        for (int w = 0; w < 16; w++) begin
            check($sformatf("final_mem%0d", w), mem[w], ref_mem[w]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
